// File: rtl/yolo_acc_top_hls_deadlock_report_unit.sv
// Aggregates per-instance deadlock monitor block flags and latches a sticky report after THRESH consecutive blocked cycles.
// Optional feature: define YOLO_ACC_TOP_DEADLOCK_TIMESTAMP_EN to add the deadlock_timestamp port and cycle counter.
module yolo_acc_top_hls_deadlock_report_unit #(
   parameter int unsigned NUM_MON = 4,
   parameter int unsigned THRESH  = 1024,
   parameter int unsigned IDX_W   = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic               clear,
   input  logic [NUM_MON-1:0] monitor_block,
   output logic               deadlock_detected,
   output logic [IDX_W-1:0]   deadlock_idx,
   output logic [NUM_MON-1:0] deadlock_mask,
   output logic               deadlock_irq,
   output logic [15:0]        stall_cycles
`ifdef YOLO_ACC_TOP_DEADLOCK_TIMESTAMP_EN
   ,
   output logic [31:0]        deadlock_timestamp
`endif
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WATCH    = 2'd1,
      DETECTED = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [15:0]        r_run_cnt;
   logic [15:0]        w_run_nxt;
   logic [15:0]        r_stall;
   logic [NUM_MON-1:0] r_mask;
   logic [IDX_W-1:0]   r_idx;
   logic               r_irq;
   logic               w_block_any;
   logic               w_detect;
   logic [IDX_W-1:0]   w_low_idx;
   logic               w_found;

   assign w_block_any = |monitor_block;

   always_comb begin
      w_low_idx = '0;
      w_found   = 1'b0;
      for (int unsigned i = 0; i < NUM_MON; i++) begin
         if (!w_found && monitor_block[i]) begin
            w_low_idx = IDX_W'(i);
            w_found   = 1'b1;
         end
      end
   end

`ifdef YOLO_ACC_TOP_DEADLOCK_TIMESTAMP_EN
   logic [31:0] r_cycle;
   logic [31:0] r_timestamp;

   // Timestamp captures the counter value seen at the detecting edge (pre-increment).
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cycle     <= '0;
         r_timestamp <= '0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (w_detect) begin
            r_timestamp <= r_cycle;
         end else if (clear) begin
            r_timestamp <= '0;
         end
      end
   end

   assign deadlock_timestamp = r_timestamp;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_run_cnt <= '0;
         r_stall   <= '0;
         r_mask    <= '0;
         r_idx     <= '0;
         r_irq     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_run_cnt <= w_run_nxt;
         r_irq     <= w_detect;
         if (clear) begin
            r_stall <= '0;
         end else if (w_block_any && enable && (r_stall != '1)) begin
            r_stall <= r_stall + 16'd1;
         end
         if (w_detect) begin
            r_mask <= monitor_block;
            r_idx  <= w_low_idx;
         end else if (clear) begin
            r_mask <= '0;
            r_idx  <= '0;
         end
      end
   end

   // run_cnt holds samples already seen, so the THRESH-th high sample arrives when it equals THRESH-1.
   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = '0;
      w_detect    = 1'b0;
      case (r_state)
         IDLE: begin
            if (!clear && enable && w_block_any) begin
               w_state_nxt = WATCH;
               w_run_nxt   = 16'd1;
            end
         end
         WATCH: begin
            if (clear || !enable || !w_block_any) begin
               w_state_nxt = IDLE;
            end else if (r_run_cnt == 16'(THRESH - 1)) begin
               w_state_nxt = DETECTED;
               w_detect    = 1'b1;
            end else begin
               w_run_nxt = r_run_cnt + 16'd1;
            end
         end
         DETECTED: begin
            if (clear) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      deadlock_detected = (r_state == DETECTED);
      deadlock_idx      = r_idx;
      deadlock_mask     = r_mask;
      deadlock_irq      = r_irq;
      stall_cycles      = r_stall;
   end

endmodule

// File: doc/yolo_acc_top_hls_deadlock_report_unit.md
YOLO_ACC_TOP_HLS_DEADLOCK_REPORT_UNIT -- requirements
Module: yolo_acc_top_hls_deadlock_report_unit

Interface
REQ-001 Parameter: NUM_MON, default 4, number of per-instance deadlock monitor block inputs (1..16).
REQ-002 Parameter: THRESH, default 1024, consecutive blocked cycles required to declare deadlock (2..65535).
REQ-003 Parameter: IDX_W, default 2, width of the monitor index output; SHALL equal max(1, clog2(NUM_MON)).
REQ-004 Port: clock  in  1  single clock; all logic on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: enable  in  1  1 = detection active; 0 = FSM held in IDLE, counters held at 0.
REQ-007 Port: clear  in  1  acknowledge/clear of a latched report.
REQ-008 Port: monitor_block  in  NUM_MON  registered block outputs of the idx monitors, bit i from monitor i.
REQ-009 Port: deadlock_detected  out  1  sticky deadlock flag.
REQ-010 Port: deadlock_idx  out  IDX_W  lowest-index monitor blocked at detection.
REQ-011 Port: deadlock_mask  out  NUM_MON  snapshot of monitor_block at detection.
REQ-012 Port: deadlock_irq  out  1  one-cycle pulse on detection.
REQ-013 Port: stall_cycles  out  16  saturating count of blocked cycles since the last clear.

Function
REQ-014 block_any SHALL be the OR of all monitor_block bits, sampled at each rising edge.
REQ-015 FSM states SHALL be IDLE, WATCH, DETECTED.
REQ-016 IDLE: block_any=1 and enable=1 -> WATCH, run_cnt=1; otherwise remain in IDLE, run_cnt=0.
REQ-017 WATCH: block_any=0 -> IDLE, run_cnt=0; block_any=1 -> run_cnt+1.
REQ-018 On the edge where block_any is sampled high for the THRESH-th consecutive time, the FSM SHALL enter DETECTED, set deadlock_detected=1, latch deadlock_mask=monitor_block and deadlock_idx=lowest set bit index, and assert deadlock_irq for exactly one cycle.
REQ-019 DETECTED: outputs held stable regardless of monitor_block until clear=1; clear=1 -> IDLE, deadlock_detected=0, mask/idx=0, run_cnt=0, stall_cycles=0.
REQ-020 clear=1 in IDLE or WATCH SHALL force IDLE, run_cnt=0, stall_cycles=0.
REQ-021 When clear and the detecting edge coincide, clear SHALL win: no detection, no irq pulse.
REQ-022 enable=0 in WATCH SHALL force IDLE with run_cnt=0; enable=0 in DETECTED SHALL NOT clear the latched report.
REQ-023 stall_cycles SHALL increment on every edge with block_any=1 and enable=1 in any state, and saturate at 0xFFFF without wrapping.
REQ-024 run_cnt SHALL be 16 bits and never wrap, because THRESH ≤ 65535.
REQ-025 Detection latency SHALL be exactly THRESH edges from the first high sample; no other output latency is permitted.

Reset
REQ-026 reset=1 SHALL force IDLE and zero run_cnt, stall_cycles, deadlock_detected, deadlock_idx, deadlock_mask and deadlock_irq on the next edge.
REQ-027 reset SHALL take priority over clear, enable and detection, including when asserted mid-WATCH or in DETECTED.

Configuration
REQ-028 Macro YOLO_ACC_TOP_DEADLOCK_TIMESTAMP_EN: when defined, add a 32-bit free-running cycle counter and output port deadlock_timestamp (out, 32 bits) that latches the counter value at the detecting edge.
REQ-029 With the macro defined, deadlock_timestamp SHALL reset to 0, clear on clear, and wrap the counter modulo 2^32.
REQ-030 Without the macro, the port and counter SHALL be absent and all other behaviour identical.

Verification (NUM_MON=4, THRESH=8)
REQ-031 monitor_block=4'b0100 held 8 cycles, enable=1 -> deadlock_detected=1 after the 8th edge; deadlock_idx=2; mask=4'b0100; irq high for 1 cycle; stall_cycles=8.
REQ-032 monitor_block=4'b0010 for 7 cycles, then 0 for 1 cycle, then 4'b0010 for 7 cycles -> no detection; stall_cycles=14.
REQ-033 monitor_block=4'b1010 for 8 cycles with clear=1 on the 8th edge -> no detection, no irq, stall_cycles=0.
REQ-034 After detection, monitor_block=0 for 20 cycles -> flags, idx and mask held; then clear=1 -> all zero, state IDLE.
REQ-035 reset=1 asserted on the 5th cycle of a blocked run -> all outputs 0; detection after release requires 8 fresh consecutive high samples.
REQ-036 Macro defined, block starts on cycle 100 after reset -> deadlock_timestamp=107 (±0 per REQ-025 convention, counter value at detecting edge).
